// File: rtl/fetch_ctrl_if.sv
// Instruction-memory read and execute handshakes between fetch_ctrl (master)
// and the memory/datapath side (slave).
interface fetch_ctrl_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ld_ir;
  logic [15:0] ir_d;
  logic        exec_start;
  logic        exec_done;
  logic        branch_taken;
  logic [15:0] branch_target;

  modport master (
    output mem_req, mem_addr, ld_ir, ir_d, exec_start,
    input  mem_ack, mem_rdata, exec_done, branch_taken, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, ld_ir, ir_d, exec_start,
    output mem_ack, mem_rdata, exec_done, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IDLE/FETCH/LOAD/EXEC/HALT sequencer for instruction fetch and execute.
// Define FETCH_TIMEOUT_EN to compile in the fetch watchdog and the err output.
module fetch_ctrl #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  fetch_ctrl_if.master bus,
  output logic [15:0]  pc,
  output logic         busy,
  output logic         halted
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic         err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] ir_q;
  logic        exec_first;
  logic        timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt;

  // Fires in the TIMEOUT-th consecutive FETCH cycle without an ack.
  assign timeout_hit = (state == S_FETCH) && !bus.mem_ack && (wd_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != S_FETCH)
        wd_cnt <= '0;
      else if (!bus.mem_ack)
        wd_cnt <= wd_cnt + 8'd1;
      if (timeout_hit)
        err <= 1'b1;
    end
  end
`else
  // TIMEOUT has no role without the watchdog.
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack)      state_nxt = S_LOAD;
        else if (timeout_hit) state_nxt = S_HALT;
      end
      S_LOAD:  state_nxt = (ir_q[15:12] == 4'hF) ? S_HALT : S_EXEC;
      S_EXEC:  if (bus.exec_done) state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.ld_ir      = 1'b0;
    bus.exec_start = 1'b0;
    busy           = 1'b0;
    halted         = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        busy        = 1'b1;
      end
      S_LOAD: begin
        bus.ld_ir = 1'b1;
        busy      = 1'b1;
      end
      S_EXEC: begin
        bus.exec_start = exec_first;
        busy           = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // pc advances in LOAD; a taken branch at the end of EXEC overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= PC_RESET;
      ir_q       <= 16'h0000;
      exec_first <= 1'b0;
    end else begin
      exec_first <= (state == S_LOAD);
      if (state == S_FETCH && bus.mem_ack)
        ir_q <= bus.mem_rdata;
      if (state == S_LOAD)
        pc <= pc + 16'd1;
      else if (state == S_EXEC && bus.exec_done && bus.branch_taken)
        pc <= bus.branch_target;
    end
  end

  assign bus.mem_addr = pc;
  assign bus.ir_d     = ir_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: one DUT with PC_RESET=0000, one with PC_RESET=FFFF.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [15:0] pc0, pc1;
  logic        busy0, busy1, halted0, halted1;
`ifdef FETCH_TIMEOUT_EN
  logic        err0, err1;
`endif
  int checks   = 0;
  int failures = 0;

  fetch_ctrl_if b0 ();
  fetch_ctrl_if b1 ();

  fetch_ctrl u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .start  (start0),
    .bus    (b0),
    .pc     (pc0),
    .busy   (busy0),
    .halted (halted0)
`ifdef FETCH_TIMEOUT_EN
    ,
    .err    (err0)
`endif
  );

  fetch_ctrl #(.PC_RESET(16'hFFFF)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .bus    (b1),
    .pc     (pc1),
    .busy   (busy1),
    .halted (halted1)
`ifdef FETCH_TIMEOUT_EN
    ,
    .err    (err1)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    b0.mem_ack = 1'b0; b0.mem_rdata = 16'h0000; b0.exec_done = 1'b0;
    b0.branch_taken = 1'b0; b0.branch_target = 16'h0000;
    b1.mem_ack = 1'b0; b1.mem_rdata = 16'h0000; b1.exec_done = 1'b0;
    b1.branch_taken = 1'b0; b1.branch_target = 16'h0000;
    step(2);

    // reset state
    chk("rst_mem_req", b0.mem_req, 16'(1'b0));
    chk("rst_ld_ir", b0.ld_ir, 16'(1'b0));
    chk("rst_exec_start", b0.exec_start, 16'(1'b0));
    chk("rst_busy", busy0, 16'(1'b0));
    chk("rst_halted", halted0, 16'(1'b0));
    chk("rst_pc0", pc0, 16'h0000);
    chk("rst_ir_d", b0.ir_d, 16'h0000);
    chk("rst_pc1", pc1, 16'hFFFF);
`ifdef FETCH_TIMEOUT_EN
    chk("rst_err", err0, 16'(1'b0));
`endif

    // idle after reset: ack/done ignored without start
    rst = 1'b0;
    b0.mem_ack = 1'b1; b0.exec_done = 1'b1;
    step(3);
    chk("idle_busy", busy0, 16'(1'b0));
    chk("idle_mem_req", b0.mem_req, 16'(1'b0));
    chk("idle_pc", pc0, 16'h0000);

    // pc wrap on the PC_RESET=FFFF instance
    start1 = 1'b1; b1.mem_ack = 1'b1; b1.mem_rdata = 16'h0123;
    step();
    start1 = 1'b0;
    chk("wrap_fetch_addr", b1.mem_addr, 16'hFFFF);
    step();
    chk("wrap_ld_ir", b1.ld_ir, 16'(1'b1));
    chk("wrap_pc_in_load", pc1, 16'hFFFF);
    step();
    chk("wrap_pc_after_load", pc1, 16'h0000);
    chk("wrap_exec_start", b1.exec_start, 16'(1'b1));

    // immediate ack and done, rdata 1234
    start0 = 1'b1; b0.mem_rdata = 16'h1234;
    step();
    start0 = 1'b0;
    chk("t1_mem_req", b0.mem_req, 16'(1'b1));
    chk("t1_mem_addr", b0.mem_addr, 16'h0000);
    chk("t1_busy", busy0, 16'(1'b1));
    step();
    chk("t1_req_drop", b0.mem_req, 16'(1'b0));
    chk("t1_ld_ir", b0.ld_ir, 16'(1'b1));
    chk("t1_ir_d", b0.ir_d, 16'h1234);
    step();
    chk("t1_ld_ir_once", b0.ld_ir, 16'(1'b0));
    chk("t1_exec_start", b0.exec_start, 16'(1'b1));
    chk("t1_pc", pc0, 16'h0001);
    step();
    chk("t1_next_req", b0.mem_req, 16'(1'b1));
    chk("t1_next_addr", b0.mem_addr, 16'h0001);
    chk("t1_exec_start_off", b0.exec_start, 16'(1'b0));

    // ack delayed 5 cycles, rdata 2000
    b0.mem_ack = 1'b0; b0.mem_rdata = 16'h2000; b0.exec_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_req_held", b0.mem_req, 16'(1'b1));
      chk("t2_addr_stable", b0.mem_addr, 16'h0001);
      chk("t2_no_ld_ir", b0.ld_ir, 16'(1'b0));
      step();
    end
    b0.mem_ack = 1'b1;
    chk("t2_req_6th", b0.mem_req, 16'(1'b1));
`ifdef FETCH_TIMEOUT_EN
    chk("t2_err_clear", err0, 16'(1'b0));
`endif
    step();
    b0.mem_ack = 1'b0;
    chk("t2_ld_ir", b0.ld_ir, 16'(1'b1));
    chk("t2_ir_d", b0.ir_d, 16'h2000);
    step();
    chk("t2_ld_ir_once", b0.ld_ir, 16'(1'b0));
    chk("t2_exec_start", b0.exec_start, 16'(1'b1));
    chk("t2_pc", pc0, 16'h0002);
    step();
    chk("t2_exec_wait", busy0, 16'(1'b1));
    chk("t2_exec_start_once", b0.exec_start, 16'(1'b0));
    chk("t2_pc_hold", pc0, 16'h0002);

    // branch taken with done
    b0.exec_done = 1'b1; b0.branch_taken = 1'b1; b0.branch_target = 16'h00A0;
    step();
    chk("t3_branch_req", b0.mem_req, 16'(1'b1));
    chk("t3_branch_addr", b0.mem_addr, 16'h00A0);

    // HALT opcode; branch inputs outside EXEC are ignored
    b0.mem_ack = 1'b1; b0.mem_rdata = 16'hF000; b0.branch_target = 16'h5555;
    step();
    chk("t4_ld_ir", b0.ld_ir, 16'(1'b1));
    chk("t4_ir_d", b0.ir_d, 16'hF000);
    step();
    chk("t4_halted", halted0, 16'(1'b1));
    chk("t4_busy", busy0, 16'(1'b0));
    chk("t4_no_exec_start", b0.exec_start, 16'(1'b0));
    chk("t4_pc", pc0, 16'h00A1);
    start0 = 1'b1;
    step(3);
    start0 = 1'b0;
    chk("t4_halt_sticky", halted0, 16'(1'b1));
    chk("t4_halt_no_req", b0.mem_req, 16'(1'b0));
    chk("t4_halt_no_exec", b0.exec_start, 16'(1'b0));
    chk("t4_halt_pc", pc0, 16'h00A1);

    // reset clears HALT asynchronously
    rst = 1'b1;
    #1;
    chk("r_halt_cleared", halted0, 16'(1'b0));
    chk("r_pc", pc0, 16'h0000);
    chk("r_ir_d", b0.ir_d, 16'h0000);
    step();
    rst = 1'b0;
    b0.exec_done = 1'b0; b0.branch_taken = 1'b0; b0.mem_rdata = 16'h1111;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    step(2);
    chk("r_exec_start", b0.exec_start, 16'(1'b1));
    chk("r_exec_pc", pc0, 16'h0001);

    // reset mid-EXEC
    rst = 1'b1;
    #1;
    chk("rx_busy", busy0, 16'(1'b0));
    chk("rx_pc", pc0, 16'h0000);
    chk("rx_exec_start", b0.exec_start, 16'(1'b0));
    step();
    chk("rx_no_ld_ir", b0.ld_ir, 16'(1'b0));
    chk("rx_pc_hold", pc0, 16'h0000);

    // reset mid-FETCH
    rst = 1'b0; b0.mem_ack = 1'b0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("rf_mem_req", b0.mem_req, 16'(1'b1));
    rst = 1'b1;
    #1;
    chk("rf_req_abort", b0.mem_req, 16'(1'b0));
    chk("rf_pc", pc0, 16'h0000);
    step();
    rst = 1'b0; b0.mem_ack = 1'b1;
    step(2);
    chk("rf_idle_busy", busy0, 16'(1'b0));
    chk("rf_no_ld_ir", b0.ld_ir, 16'(1'b0));
    chk("rf_pc_hold", pc0, 16'h0000);

    // FETCH with no ack
    b0.mem_ack = 1'b0; start0 = 1'b1;
    step();
    start0 = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    step(254);
    chk("wd_still_fetch", b0.mem_req, 16'(1'b1));
    chk("wd_err_pre", err0, 16'(1'b0));
    chk("wd_halted_pre", halted0, 16'(1'b0));
    step();
    chk("wd_err", err0, 16'(1'b1));
    chk("wd_halted", halted0, 16'(1'b1));
    chk("wd_no_ld_ir", b0.ld_ir, 16'(1'b0));
    chk("wd_req_off", b0.mem_req, 16'(1'b0));
    b0.mem_ack = 1'b1;
    step(3);
    chk("wd_err_sticky", err0, 16'(1'b1));
    chk("wd_halt_sticky", halted0, 16'(1'b1));
`else
    step(300);
    chk("wait_req", b0.mem_req, 16'(1'b1));
    chk("wait_busy", busy0, 16'(1'b1));
    chk("wait_halted", halted0, 16'(1'b0));
    chk("wait_addr", b0.mem_addr, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
